// File: rtl/if_fetch_queue_if.sv
// Signal bundle between the fetch queue, the instruction memory and decode.
// Handshake: out_valid/out_ready are strict valid/ready; a head entry transfers on a cycle where both are high.
// Once raised, out_valid and the head payload hold until that transfer, unless a redirect or reset flushes the queue.
interface if_fetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int ALEN  = 32,
   parameter int DEPTH = 4
);
   localparam int OW = $clog2(DEPTH + 1);

   logic [ALEN-1:0] imem_addr;
   logic            imem_en;
   logic [31:0]     imem_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_pc_plus_4;
   logic [OW-1:0]   occupancy;

   modport master (
      output imem_addr, imem_en, out_valid, out_instr, out_pc, out_pc_plus_4, occupancy,
      input  imem_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_addr, imem_en, out_valid, out_instr, out_pc, out_pc_plus_4, occupancy,
      output imem_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, tracks in-flight memory reads with a tag
// shift register, and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
module if_fetch_queue #(
   parameter int              XLEN         = 32,
   parameter int              ALEN         = 32,
   parameter int              DEPTH        = 4,
   parameter int              IMEM_LATENCY = 1,
   parameter logic [XLEN-1:0] RESET_PC     = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   if_fetch_queue_if.master fq
);
   localparam int OW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + IMEM_LATENCY + 1);

   logic [XLEN-1:0]                   fetch_pc_q, fetch_pc_d;
   logic [IMEM_LATENCY-1:0]           tag_vld_q, tag_vld_d;
   logic [IMEM_LATENCY-1:0][XLEN-1:0] tag_pc_q, tag_pc_d;
   logic [31:0]                       fifo_instr_q [DEPTH];
   logic [XLEN-1:0]                   fifo_pc_q [DEPTH];
   logic [PW-1:0]                     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]                     wr_ptr_q, wr_ptr_d;
   logic [OW-1:0]                     count_q, count_d;
   logic [CW-1:0]                     inflight;
   logic                              issue;
   logic                              push;
   logic                              pop;
   logic                              head_vld;
   logic                              unused_ok;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < IMEM_LATENCY; i++) begin
         inflight = inflight + CW'(tag_vld_q[i]);
      end
   end

   // Credit counts every outstanding request, including the one returning this cycle,
   // so a request is only sent when its data is guaranteed a FIFO slot.
   assign head_vld = (count_q != '0);
   assign issue    = rst_n && !fq.redirect_valid && ((CW'(count_q) + inflight) < CW'(DEPTH));
   assign push     = tag_vld_q[IMEM_LATENCY-1] && !fq.redirect_valid;
   assign pop      = head_vld && fq.out_ready && !fq.redirect_valid;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      tag_vld_d  = '0;
      tag_pc_d   = tag_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (fq.redirect_valid) begin
         fetch_pc_d = {fq.redirect_pc[XLEN-1:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
         tag_vld_d[0] = issue;
         tag_pc_d[0]  = fetch_pc_q;
         for (int i = 1; i < IMEM_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_pc_d[i]  = tag_pc_q[i-1];
         end
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + OW'(push) - OW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         tag_vld_q  <= '0;
         tag_pc_q   <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         tag_vld_q  <= tag_vld_d;
         tag_pc_q   <= tag_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= fq.imem_data;
         fifo_pc_q[wr_ptr_q]    <= tag_pc_q[IMEM_LATENCY-1];
      end
   end

   assign fq.imem_en       = issue;
   assign fq.imem_addr     = fetch_pc_q[ALEN-1:0];
   assign fq.out_valid     = head_vld;
   assign fq.out_instr     = head_vld ? fifo_instr_q[rd_ptr_q] : '0;
   assign fq.out_pc        = head_vld ? fifo_pc_q[rd_ptr_q] : '0;
   assign fq.out_pc_plus_4 = head_vld ? (fifo_pc_q[rd_ptr_q] + XLEN'(4)) : '0;
   assign fq.occupancy     = count_q;
   assign unused_ok        = ^fq.redirect_pc[1:0];
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios followed by random ready/redirect/reset traffic,
// checked against a stream model of the fetch sequence.
module tb_if_fetch_queue;
   localparam int          XLEN     = 32;
   localparam int          ALEN     = 32;
   localparam int          DEPTH    = 4;
   localparam int          LAT      = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   if_fetch_queue_if #(.XLEN(XLEN), .ALEN(ALEN), .DEPTH(DEPTH)) fq ();

   if_fetch_queue #(
      .XLEN(XLEN), .ALEN(ALEN), .DEPTH(DEPTH), .IMEM_LATENCY(LAT), .RESET_PC(RESET_PC)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fq    (fq)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
   endfunction

   // Memory model with two cycles of read latency; unrequested cycles return a junk word.
   logic [31:0] m_a1, m_a2;
   always @(posedge clk) begin
      m_a1 <= fq.imem_en ? fq.imem_addr : 32'hBAD0_0000;
      m_a2 <= m_a1;
   end
   assign fq.imem_data = mem_word(m_a2);

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_issue;
   int          outstanding;
   int          en_cnt = 0;
   int          since_pop;
   logic        prev_hold;
   logic [31:0] prev_pc, prev_instr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Every flush restarts both the issue stream and the expected output stream at target.
   task automatic model_flush(input logic [31:0] target);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(target + 32'(4 * i));
      exp_issue   = target;
      outstanding = 0;
      since_pop   = 0;
      prev_hold   = 1'b0;
   endtask

   // Monitor: samples on the falling edge what the next rising edge will act on.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst_n) begin
         model_flush(RESET_PC);
      end else begin
         chk("valid_vs_occ", 32'(fq.out_valid), 32'(fq.occupancy != 0));
         chk("occ_le_outstanding", 32'(int'(fq.occupancy) <= outstanding), 32'd1);
         chk("imem_en_credit", 32'(fq.imem_en), 32'(!fq.redirect_valid && outstanding < DEPTH));
         if (prev_hold) begin
            chk("hold_valid", 32'(fq.out_valid), 32'd1);
            chk("hold_pc", fq.out_pc, prev_pc);
            chk("hold_instr", fq.out_instr, prev_instr);
         end
         if (fq.imem_en) begin
            chk("imem_addr", fq.imem_addr, exp_issue);
            exp_issue = exp_issue + 32'd4;
            outstanding++;
            en_cnt++;
         end
         if (fq.out_valid && fq.out_ready && !fq.redirect_valid) begin
            e = exp_q.pop_front();
            chk("out_pc", fq.out_pc, e);
            chk("out_instr", fq.out_instr, mem_word(e));
            chk("out_pc_plus_4", fq.out_pc_plus_4, e + 32'd4);
            if (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
            outstanding--;
            since_pop = 0;
         end else begin
            since_pop++;
         end
         chk("progress", 32'(since_pop > 64), 32'd0);
         prev_hold  = fq.out_valid && !fq.out_ready && !fq.redirect_valid;
         prev_pc    = fq.out_pc;
         prev_instr = fq.out_instr;
         if (fq.redirect_valid) model_flush({fq.redirect_pc[31:2], 2'b00});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_once(input logic [31:0] target);
      step();
      fq.redirect_valid = 1'b1;
      fq.redirect_pc    = target;
      step();
      fq.redirect_valid = 1'b0;
   endtask

   // Called at a falling edge; waits a bounded number of cycles for the head to become valid.
   task automatic wait_valid(input string name, input int max_cyc);
      int n = 0;
      while (!fq.out_valid && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(fq.out_valid), 32'd1);
   endtask

   initial begin
      int base;
      rst_n             = 1'b0;
      fq.out_ready      = 1'b0;
      fq.redirect_valid = 1'b0;
      fq.redirect_pc    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(fq.out_valid), 32'd0);
      chk("rst_occupancy", 32'(fq.occupancy), 32'd0);
      chk("rst_imem_en", 32'(fq.imem_en), 32'd0);
      chk("rst_imem_addr", fq.imem_addr, RESET_PC);
      chk("rst_out_instr", fq.out_instr, 32'd0);
      chk("rst_out_pc", fq.out_pc, 32'd0);
      chk("rst_out_pc4", fq.out_pc_plus_4, 32'd0);

      // Streaming from reset: first entry LAT+1 cycles after the first issue, then no bubbles.
      step();
      rst_n        = 1'b1;
      fq.out_ready = 1'b1;
      @(negedge clk);
      chk("t1_first_en", 32'(fq.imem_en), 32'd1);
      chk("t1_first_addr", fq.imem_addr, RESET_PC);
      repeat (3) @(negedge clk);
      chk("t1_first_valid", 32'(fq.out_valid), 32'd1);
      chk("t1_first_pc", fq.out_pc, RESET_PC);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("t1_no_bubble", 32'(fq.out_valid), 32'd1);
      end

      // Stalled decode: exactly DEPTH requests, then one pop frees exactly one credit.
      step();
      fq.redirect_valid = 1'b1;
      fq.redirect_pc    = 32'h0000_3000;
      fq.out_ready      = 1'b0;
      step();
      fq.redirect_valid = 1'b0;
      base = en_cnt;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("t2_pulses", 32'(en_cnt - base), 32'(DEPTH));
      chk("t2_full_occ", 32'(fq.occupancy), 32'(DEPTH));
      chk("t2_full_en", 32'(fq.imem_en), 32'd0);
      step();
      fq.out_ready = 1'b1;
      step();
      fq.out_ready = 1'b0;
      @(negedge clk);
      chk("t2_occ_after_pop", 32'(fq.occupancy), 32'(DEPTH - 1));
      chk("t2_reissue", 32'(fq.imem_en), 32'd1);
      @(negedge clk);
      chk("t2_refull", 32'(fq.imem_en), 32'd0);

      // Redirect to a misaligned target with entries buffered and requests in flight.
      step();
      fq.redirect_valid = 1'b1;
      fq.redirect_pc    = 32'h0000_5000;
      step();
      fq.redirect_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      fq.redirect_valid = 1'b1;
      fq.redirect_pc    = 32'h0000_2002;
      @(negedge clk);
      chk("t3_occ_before", 32'(fq.occupancy), 32'd2);
      step();
      fq.redirect_valid = 1'b0;
      fq.out_ready      = 1'b1;
      @(negedge clk);
      chk("t3_occ_flushed", 32'(fq.occupancy), 32'd0);
      chk("t3_valid_flushed", 32'(fq.out_valid), 32'd0);
      chk("t3_en", 32'(fq.imem_en), 32'd1);
      chk("t3_addr", fq.imem_addr, 32'h0000_2000);
      wait_valid("t3_wait", 10);
      chk("t3_first_pc", fq.out_pc, 32'h0000_2000);

      // Back-to-back redirects: the second target wins.
      repeat (5) step();
      fq.redirect_valid = 1'b1;
      fq.redirect_pc    = 32'h0000_0400;
      step();
      fq.redirect_pc    = 32'h0000_0800;
      step();
      fq.redirect_valid = 1'b0;
      @(negedge clk);
      chk("t4_addr", fq.imem_addr, 32'h0000_0800);
      wait_valid("t4_wait", 10);
      chk("t4_first_pc", fq.out_pc, 32'h0000_0800);

      // Address wrap at the top of the PC space.
      redirect_once(32'hFFFF_FFF8);
      repeat (3) @(negedge clk);
      chk("t5_wrap_addr", fq.imem_addr, 32'h0000_0000);
      @(negedge clk);
      chk("t5_pc_f8", fq.out_pc, 32'hFFFF_FFF8);
      @(negedge clk);
      chk("t5_pc_fc", fq.out_pc, 32'hFFFF_FFFC);
      chk("t5_pc4_wrap", fq.out_pc_plus_4, 32'h0000_0000);

      // Asynchronous reset mid-stream with requests in flight.
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_valid_async", 32'(fq.out_valid), 32'd0);
      chk("t6_occ_async", 32'(fq.occupancy), 32'd0);
      chk("t6_en_async", 32'(fq.imem_en), 32'd0);
      chk("t6_addr_async", fq.imem_addr, RESET_PC);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_restart_addr", fq.imem_addr, RESET_PC);
      wait_valid("t6_wait", 10);
      chk("t6_first_pc", fq.out_pc, RESET_PC);

      // Random traffic: stalls, redirects to arbitrary targets, occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         step();
         fq.out_ready      = ($urandom_range(0, 3) != 0);
         fq.redirect_valid = ($urandom_range(0, 19) == 0);
         fq.redirect_pc    = $urandom;
         if ($urandom_range(0, 499) == 0) begin
            #2;
            rst_n = 1'b0;
            @(posedge clk);
            #2;
            rst_n = 1'b1;
         end
      end
      step();
      fq.redirect_valid = 1'b0;
      fq.out_ready      = 1'b1;
      repeat (20) step();

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
